baud_tick_gen: RTL and testbench

Programmable fractional baud-rate tick generator for the UART datapath. It replaces the fixed-ratio square-wave divider with a runtime-loadable divisor (integer plus fractional part), an oversample tick, bit-boundary and mid-bit strobes, and a phase-resync input for receiver start-bit alignment. It sits between the system clock and the UART TX/RX engines, which consume only its single-cycle strobes.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/baud_phase_counter.sv | 61 ++++++
 rtl/baud_tick_gen.sv | 141 ++++++++++++++
 tb/tb_baud_tick_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default constants, the baud divisor helper and
// the generator state encoding.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned DIV_MIN            = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Clocks per oversample tick as a fixed-point value with frac_w fractional
  // bits, rounded to nearest. The caller splits it into integer and fraction.
  function automatic logic [63:0] default_div(input logic [63:0] clk_freq,
                                              input logic [63:0] baud_rate,
                                              input logic [63:0] oversample,
                                              input int unsigned frac_w);
    logic [63:0] den;
    den = baud_rate * oversample;
    return ((clk_freq << frac_w) + (den >> 1)) / den;
  endfunction

endpackage

// File: rtl/baud_phase_counter.sv
// Cycle counter and fractional accumulator for one oversample period.
// A period lasts D cycles, or D+1 when acc + F carries out of FRAC_WIDTH bits.
module baud_phase_counter #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  run_i,
  input  logic [DIV_WIDTH-1:0]  div_int_i,
  input  logic [FRAC_WIDTH-1:0] div_frac_i,
  output logic                  period_end_o
);

  localparam logic [DIV_WIDTH:0] CNT_ONE = (DIV_WIDTH + 1)'(1);

  logic [DIV_WIDTH:0]    cnt_q, cnt_d;
  logic [DIV_WIDTH:0]    cnt_last;
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [FRAC_WIDTH:0]   acc_sum;

  // acc_q holds the accumulator as it stood at the start of this period, so
  // the carry (and hence this period's length) is stable for the whole period.
  assign acc_sum      = {1'b0, acc_q} + {1'b0, div_frac_i};
  assign cnt_last     = {1'b0, div_int_i} + {{DIV_WIDTH{1'b0}}, acc_sum[FRAC_WIDTH]} - CNT_ONE;
  assign period_end_o = run_i && (cnt_q == cnt_last);

  // Next-state for counter and accumulator; load restarts the fraction sequence.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (run_i) begin
      if (cnt_q == cnt_last) begin
        cnt_d = '0;
        acc_d = acc_sum[FRAC_WIDTH-1:0];
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    if (load_i) begin
      acc_d = '0;
    end
  end

  // Counter and accumulator registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable fractional baud tick generator: IDLE/RUN control, divisor
// handshake with bit-boundary update, tick index and registered strobes.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_sync,
  input  logic [DIV_WIDTH-1:0]  i_div_int,
  input  logic [FRAC_WIDTH-1:0] i_div_frac,
  input  logic                  i_div_valid,
  output logic                  o_div_ready,
  output logic                  o_div_err,
  output logic                  o_os_tick,
  output logic                  o_mid_tick,
  output logic                  o_bit_tick,
  output logic                  o_baud_clk
);

  localparam int unsigned IDX_W = $clog2(OVERSAMPLE);
  localparam logic [63:0] DEF_FIX =
    default_div(64'(CLK_FREQ), 64'(BAUD_RATE), 64'(OVERSAMPLE), FRAC_WIDTH);
  localparam logic [DIV_WIDTH-1:0]  DEF_INT    = DEF_FIX[FRAC_WIDTH +: DIV_WIDTH];
  localparam logic [FRAC_WIDTH-1:0] DEF_FRAC   = DEF_FIX[FRAC_WIDTH-1:0];
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]      IDX_PREMID = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);

  state_e                state_q, state_d;
  logic                  run, clear, fire, mid_fire, bit_fire, apply;
  logic                  accept, bad_div;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  os_q, mid_q, bit_q, baud_q, err_q;
  logic                  pend_q;
  logic [DIV_WIDTH-1:0]  div_int_q, pend_int_q;
  logic [FRAC_WIDTH-1:0] div_frac_q, pend_frac_q;

  // Sync only matters in RUN; it and any state change restart the bit phase.
  assign run      = (state_q == ST_RUN) && i_enable && !i_sync;
  assign clear    = (state_q != state_d) || ((state_q == ST_RUN) && i_enable && i_sync);
  assign mid_fire = fire && (idx_q == IDX_PREMID);
  assign bit_fire = fire && (idx_q == IDX_LAST);
  assign apply    = pend_q && ((state_q == ST_IDLE) || bit_fire);
  assign accept   = i_div_valid && !pend_q;
  assign bad_div  = i_div_int < DIV_WIDTH'(DIV_MIN);

  baud_phase_counter #(
    .DIV_WIDTH (DIV_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH)
  ) u_phase (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .clear_i     (clear),
    .load_i      (apply),
    .run_i       (run),
    .div_int_i   (div_int_q),
    .div_frac_i  (div_frac_q),
    .period_end_o(fire)
  );

  // Next-state logic: IDLE while disabled, RUN while enabled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_enable)  state_d = ST_RUN;
      ST_RUN:  if (!i_enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Tick index advances once per oversample tick and wraps at the bit boundary.
  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (fire) begin
      idx_d = bit_fire ? '0 : idx_q + IDX_ONE;
    end
  end

  // State, tick index and strobe registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      os_q    <= 1'b0;
      mid_q   <= 1'b0;
      bit_q   <= 1'b0;
      baud_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      os_q    <= fire;
      mid_q   <= mid_fire;
      bit_q   <= bit_fire;
      if (clear) begin
        baud_q <= 1'b0;
      end else if (mid_fire || bit_fire) begin
        baud_q <= ~baud_q;
      end
    end
  end

  // Divisor handshake: reject D < DIV_MIN, hold one request until it can apply.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      div_int_q   <= DEF_INT;
      div_frac_q  <= DEF_FRAC;
    end else begin
      err_q <= accept && bad_div;
      if (apply) begin
        div_int_q  <= pend_int_q;
        div_frac_q <= pend_frac_q;
        pend_q     <= 1'b0;
      end else if (accept && !bad_div) begin
        pend_int_q  <= i_div_int;
        pend_frac_q <= i_div_frac;
        pend_q      <= 1'b1;
      end
    end
  end

  assign o_div_ready = ~pend_q;
  assign o_div_err   = err_q;
  assign o_os_tick   = os_q;
  assign o_mid_tick  = mid_q;
  assign o_bit_tick  = bit_q;
  assign o_baud_clk  = baud_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed testbench for baud_tick_gen at default parameters (D = 54, F = 4).
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable, i_sync, i_div_valid;
  logic [15:0] i_div_int;
  logic [3:0]  i_div_frac;
  logic        o_div_ready, o_div_err, o_os_tick, o_mid_tick, o_bit_tick, o_baud_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n, first_os, mid_n, bit_n, os_cnt, n55, n_other, baud_hi, last, early, any_strobe;

  always #5 clk = ~clk;

  baud_tick_gen dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (i_enable),
    .i_sync     (i_sync),
    .i_div_int  (i_div_int),
    .i_div_frac (i_div_frac),
    .i_div_valid(i_div_valid),
    .o_div_ready(o_div_ready),
    .o_div_err  (o_div_err),
    .o_os_tick  (o_os_tick),
    .o_mid_tick (o_mid_tick),
    .o_bit_tick (o_bit_tick),
    .o_baud_clk (o_baud_clk)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic strobe(input int sel);
    case (sel)
      0:       return o_os_tick;
      1:       return o_mid_tick;
      default: return o_bit_tick;
    endcase
  endfunction

  // Cycles until the selected strobe is seen; -1 if the bound runs out.
  task automatic wait_strobe(input int sel, input int max, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!strobe(sel) && cnt < max);
    if (!strobe(sel)) cnt = -1;
  endtask

  task automatic request(input logic [15:0] d, input logic [3:0] f);
    i_div_int   = d;
    i_div_frac  = f;
    i_div_valid = 1'b1;
    tick();
    i_div_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; i_enable = 1'b0; i_sync = 1'b0; i_div_valid = 1'b0;
    i_div_int = '0; i_div_frac = '0;
    #1;
    check("rst_os",    o_os_tick,   0);
    check("rst_mid",   o_mid_tick,  0);
    check("rst_bit",   o_bit_tick,  0);
    check("rst_baud",  o_baud_clk,  0);
    check("rst_err",   o_div_err,   0);
    check("rst_ready", o_div_ready, 1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Default divisor 54 + 4/16: first bit at 868 edges after enable.
    i_enable = 1'b1;
    wait_strobe(2, 2000, n);
    check("def_first_bit", n, 869);
    os_cnt = 0; n55 = 0; n_other = 0; baud_hi = 0; last = 0; mid_n = 0; bit_n = 0;
    for (int c = 1; c <= 868; c++) begin
      tick();
      if (o_baud_clk) baud_hi++;
      if (o_os_tick) begin
        os_cnt++;
        if (c - last == 55) n55++;
        else if (c - last != 54) n_other++;
        last = c;
      end
      if (o_mid_tick && mid_n == 0) mid_n = c;
      if (o_bit_tick && bit_n == 0) bit_n = c;
    end
    check("def_bit_period", bit_n,   868);
    check("def_os_count",   os_cnt,  16);
    check("def_os_55s",     n55,     4);
    check("def_os_other",   n_other, 0);
    check("def_mid_at",     mid_n,   434);
    check("def_baud_high",  baud_hi, 434);

    // Disable: strobes stay quiet in IDLE.
    i_enable = 1'b0;
    any_strobe = 0;
    repeat (6) begin
      tick();
      if (o_os_tick || o_mid_tick || o_bit_tick) any_strobe++;
    end
    check("idle_quiet", any_strobe, 0);

    // Load D = 4, F = 0 in IDLE: ready drops for one cycle.
    request(16'd4, 4'd0);
    check("idle_ld_ready_lo", o_div_ready, 0);
    tick();
    check("idle_ld_ready_hi", o_div_ready, 1);
    i_enable = 1'b1;
    first_os = 0; mid_n = 0; bit_n = 0; os_cnt = 0;
    for (int c = 1; c <= 100 && bit_n == 0; c++) begin
      tick();
      if (o_os_tick) begin
        os_cnt++;
        if (first_os == 0) first_os = c;
      end
      if (o_mid_tick && mid_n == 0) mid_n = c;
      if (o_bit_tick && bit_n == 0) bit_n = c;
    end
    check("d4_first_os", first_os, 5);
    check("d4_mid",      mid_n,    33);
    check("d4_bit",      bit_n,    65);
    check("d4_os_count", os_cnt,   16);

    // F = 8 requested in RUN: applies at next bit boundary, then 4,5,4,5.
    request(16'd4, 4'd8);
    check("f8_ready_lo", o_div_ready, 0);
    wait_strobe(2, 100, n);
    check("f8_bit_wait", n, 63);
    check("f8_ready_hi", o_div_ready, 1);
    wait_strobe(0, 20, n); check("f8_p1", n, 4);
    wait_strobe(0, 20, n); check("f8_p2", n, 5);
    wait_strobe(0, 20, n); check("f8_p3", n, 4);
    wait_strobe(0, 20, n); check("f8_p4", n, 5);

    // Deferred update to D = 10: ready held low until the bit tick.
    request(16'd10, 4'd0);
    check("dfr_ready_lo", o_div_ready, 0);
    early = 0; n = 0;
    do begin
      tick();
      n++;
      if (o_div_ready && !o_bit_tick) early = 1;
    end while (!o_bit_tick && n < 300);
    check("dfr_bit_seen", o_bit_tick,  1);
    check("dfr_early",    early,       0);
    check("dfr_ready_hi", o_div_ready, 1);
    wait_strobe(0, 40, n); check("dfr_p1", n, 10);
    wait_strobe(0, 40, n); check("dfr_p2", n, 10);

    // Illegal D = 1: one-cycle error pulse, divisor unchanged.
    request(16'd1, 4'd0);
    check("ill_err_hi", o_div_err,   1);
    check("ill_ready",  o_div_ready, 1);
    tick();
    check("ill_err_lo", o_div_err,   0);
    wait_strobe(0, 40, n);
    wait_strobe(0, 40, n); check("ill_period", n, 10);

    // Resync exactly on a due os tick.
    repeat (9) tick();
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
    check("sync_os",      o_os_tick,                 0);
    check("sync_mid_bit", {o_mid_tick, o_bit_tick},  0);
    check("sync_baud",    o_baud_clk,                0);
    first_os = 0; mid_n = 0; os_cnt = 0;
    for (int c = 1; c <= 200 && mid_n == 0; c++) begin
      tick();
      if (o_os_tick) begin
        os_cnt++;
        if (first_os == 0) first_os = c;
      end
      if (o_mid_tick) mid_n = c;
    end
    check("sync_first_os", first_os,   10);
    check("sync_mid",      mid_n,      80);
    check("sync_os_count", os_cnt,     8);
    check("sync_baud_mid", o_baud_clk, 1);

    // Asynchronous reset mid-bit with a divisor update pending.
    request(16'd6, 4'd0);
    check("rr_ready_lo", o_div_ready, 0);
    wait_strobe(0, 20, n);
    check("rr_os_before",   n,          9);
    check("rr_baud_before", o_baud_clk, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_os",    o_os_tick,   0);
    check("rr_mid",   o_mid_tick,  0);
    check("rr_baud",  o_baud_clk,  0);
    check("rr_ready", o_div_ready, 1);
    check("rr_err",   o_div_err,   0);
    i_enable = 1'b0;
    #20;
    rst_n = 1'b1;
    tick();
    tick();
    check("rr_ready_after", o_div_ready, 1);
    i_enable = 1'b1;
    wait_strobe(0, 200, n); check("rr_first_os", n, 55);
    wait_strobe(0, 200, n); check("rr_second_os", n, 54);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
